// File: rtl/linebuf_5row.sv
// +----------------------------------------------------------------------------+
// | linebuf_5row : four-line buffer presenting 5 vertically aligned row taps   |
// | Option macro: LINEBUF_ZERO_PAD_EN (zero top-border padding)    Rev 1.0    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module linebuf_5row #(
  parameter int WIDTH      = 24,
  parameter int PIC_WIDTH  = 480,
  parameter int PIC_HEIGHT = 272
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_in,
  input  logic                          sof,
  input  logic [WIDTH-1:0]              din,
  output logic                          valid_out,
  output logic [WIDTH-1:0]              dout1,
  output logic [WIDTH-1:0]              dout2,
  output logic [WIDTH-1:0]              dout3,
  output logic [WIDTH-1:0]              dout4,
  output logic [WIDTH-1:0]              dout5,
  output logic [$clog2(PIC_WIDTH)-1:0]  col_out,
  output logic [$clog2(PIC_HEIGHT)-1:0] row_out
);

  localparam int              CW       = $clog2(PIC_WIDTH);
  localparam int              RW       = $clog2(PIC_HEIGHT);
  localparam logic [CW-1:0]   COL_LAST = CW'(PIC_WIDTH - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(PIC_HEIGHT - 1);
  localparam logic [2:0]      FILL_MAX = 3'd4;

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [2:0]       fill_q, fill_d;

  logic             w_sof_acc;
  logic             w_line_end;
  logic             w_frame_end;
  logic [CW-1:0]    w_cur_col;
  logic [RW-1:0]    w_cur_row;
  logic [2:0]       w_cur_fill;

  logic [WIDTH-1:0] mem1 [PIC_WIDTH];
  logic [WIDTH-1:0] mem2 [PIC_WIDTH];
  logic [WIDTH-1:0] mem3 [PIC_WIDTH];
  logic [WIDTH-1:0] mem4 [PIC_WIDTH];

  logic [WIDTH-1:0] w_rd1, w_rd2, w_rd3, w_rd4;
  logic [WIDTH-1:0] w_tap1, w_tap2, w_tap3, w_tap4;
  logic             w_vld;

  logic             valid_q;
  logic [WIDTH-1:0] dout1_q, dout2_q, dout3_q, dout4_q, dout5_q;
  logic [CW-1:0]    col_out_q;
  logic [RW-1:0]    row_out_q;

  // A qualified sof relocates the current pixel to (0,0) and restarts priming.
  always_comb begin
    w_sof_acc  = valid_in && sof;
    w_cur_col  = col_q;
    w_cur_row  = row_q;
    w_cur_fill = fill_q;
    if (w_sof_acc) begin
      w_cur_col  = '0;
      w_cur_row  = '0;
      w_cur_fill = '0;
    end
    w_line_end  = (w_cur_col == COL_LAST);
    w_frame_end = w_line_end && (w_cur_row == ROW_LAST);
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    fill_d = fill_q;
    if (valid_in) begin
      col_d  = w_line_end ? '0 : w_cur_col + 1'b1;
      row_d  = w_cur_row;
      fill_d = w_cur_fill;
      if (w_frame_end) begin
        row_d  = '0;
        fill_d = '0;
      end else if (w_line_end) begin
        row_d = w_cur_row + 1'b1;
        if (w_cur_fill != FILL_MAX) begin
          fill_d = w_cur_fill + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      fill_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      fill_q <= fill_d;
    end
  end

  // Read-before-write: the old column contents shift one line down the chain.
  always_comb begin
    w_rd1 = mem1[w_cur_col];
    w_rd2 = mem2[w_cur_col];
    w_rd3 = mem3[w_cur_col];
    w_rd4 = mem4[w_cur_col];
  end

  always_ff @(posedge clk) begin
    if (valid_in) begin
      mem1[w_cur_col] <= din;
      mem2[w_cur_col] <= w_rd1;
      mem3[w_cur_col] <= w_rd2;
      mem4[w_cur_col] <= w_rd3;
    end
  end

`ifdef LINEBUF_ZERO_PAD_EN
  // Taps whose source line lies above the frame top read as zero.
  always_comb begin
    w_vld  = 1'b1;
    w_tap1 = (w_cur_fill >= 3'd4) ? w_rd4 : '0;
    w_tap2 = (w_cur_fill >= 3'd3) ? w_rd3 : '0;
    w_tap3 = (w_cur_fill >= 3'd2) ? w_rd2 : '0;
    w_tap4 = (w_cur_fill >= 3'd1) ? w_rd1 : '0;
  end
`else
  always_comb begin
    w_vld  = (w_cur_fill == FILL_MAX);
    w_tap1 = w_rd4;
    w_tap2 = w_rd3;
    w_tap3 = w_rd2;
    w_tap4 = w_rd1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      dout1_q   <= '0;
      dout2_q   <= '0;
      dout3_q   <= '0;
      dout4_q   <= '0;
      dout5_q   <= '0;
      col_out_q <= '0;
      row_out_q <= '0;
    end else if (valid_in) begin
      valid_q   <= w_vld;
      dout1_q   <= w_tap1;
      dout2_q   <= w_tap2;
      dout3_q   <= w_tap3;
      dout4_q   <= w_tap4;
      dout5_q   <= din;
      col_out_q <= w_cur_col;
      row_out_q <= w_cur_row;
    end else begin
      valid_q   <= 1'b0;
    end
  end

  assign valid_out = valid_q;
  assign dout1     = dout1_q;
  assign dout2     = dout2_q;
  assign dout3     = dout3_q;
  assign dout4     = dout4_q;
  assign dout5     = dout5_q;
  assign col_out   = col_out_q;
  assign row_out   = row_out_q;

endmodule

`default_nettype wire

// File: tb/tb_linebuf_5row.sv
// +----------------------------------------------------------------------------+
// | tb_linebuf_5row : directed self-checking bench for linebuf_5row   Rev 1.0 |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_linebuf_5row;

  localparam int W  = 24;
  localparam int PW = 8;
  localparam int PH = 6;
`ifdef LINEBUF_ZERO_PAD_EN
  localparam bit ZP        = 1'b1;
  localparam int FRAME_VLD = 48;
`else
  localparam bit ZP        = 1'b0;
  localparam int FRAME_VLD = 16;
`endif

  logic         clk;
  logic         rst_n;
  logic         valid_in;
  logic         sof;
  logic [W-1:0] din;
  logic         valid_out;
  logic [W-1:0] dout1, dout2, dout3, dout4, dout5;
  logic [2:0]   col_out;
  logic [2:0]   row_out;

  linebuf_5row #(
    .WIDTH      (W),
    .PIC_WIDTH  (PW),
    .PIC_HEIGHT (PH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .sof       (sof),
    .din       (din),
    .valid_out (valid_out),
    .dout1     (dout1),
    .dout2     (dout2),
    .dout3     (dout3),
    .dout4     (dout4),
    .dout5     (dout5),
    .col_out   (col_out),
    .row_out   (row_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           mr, mc, vcount;
  logic [W-1:0] last5;
  int           last_col, last_row;

  function automatic logic [W-1:0] pix(input int r, input int c);
    return {8'h00, 8'(r), 8'(c)};
  endfunction

  // Tap k (1..5) sources line r-(5-k); lines above the frame read as zero.
  function automatic logic [W-1:0] tap_exp(input int r, input int c, input int k);
    int sr;
    sr = r - (5 - k);
    if (sr < 0) return '0;
    return pix(sr, c);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pix_beat(input logic s);
    logic ev;
    if (s) begin
      mr = 0;
      mc = 0;
    end
    valid_in = 1'b1;
    sof      = s;
    din      = pix(mr, mc);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sof      = 1'b0;
    din      = '0;
    ev = ZP || (mr >= 4);
    check_val("valid_out", 32'(valid_out), 32'(ev));
    check_val("dout5", 32'(dout5), 32'(pix(mr, mc)));
    check_val("col_out", 32'(col_out), 32'(mc));
    check_val("row_out", 32'(row_out), 32'(mr));
    if (ev) begin
      vcount++;
      check_val("dout1", 32'(dout1), 32'(tap_exp(mr, mc, 1)));
      check_val("dout2", 32'(dout2), 32'(tap_exp(mr, mc, 2)));
      check_val("dout3", 32'(dout3), 32'(tap_exp(mr, mc, 3)));
      check_val("dout4", 32'(dout4), 32'(tap_exp(mr, mc, 4)));
    end
    last5    = pix(mr, mc);
    last_col = mc;
    last_row = mr;
    mc++;
    if (mc == PW) begin
      mc = 0;
      mr++;
      if (mr == PH) mr = 0;
    end
  endtask

  task automatic idle_cyc();
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    check_val("idle_valid", 32'(valid_out), 32'h0);
    check_val("idle_dout5_hold", 32'(dout5), 32'(last5));
    check_val("idle_col_hold", 32'(col_out), 32'(last_col));
    check_val("idle_row_hold", 32'(row_out), 32'(last_row));
  endtask

  task automatic run_frame(input logic s, input bit gaps, input string tag);
    vcount = 0;
    for (int i = 0; i < PW * PH; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) idle_cyc();
      pix_beat(s && (i == 0));
    end
    check_val({tag, "_vld_count"}, 32'(vcount), 32'(FRAME_VLD));
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_valid"}, 32'(valid_out), 32'h0);
    check_val({tag, "_dout1"}, 32'(dout1), 32'h0);
    check_val({tag, "_dout2"}, 32'(dout2), 32'h0);
    check_val({tag, "_dout3"}, 32'(dout3), 32'h0);
    check_val({tag, "_dout4"}, 32'(dout4), 32'h0);
    check_val({tag, "_dout5"}, 32'(dout5), 32'h0);
    check_val({tag, "_col"}, 32'(col_out), 32'h0);
    check_val({tag, "_row"}, 32'(row_out), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    sof      = 1'b0;
    din      = '0;
    mr = 0; mc = 0; vcount = 0;
    last5 = '0; last_col = 0; last_row = 0;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full frame, continuous, with hand-computed taps at the first full column.
    vcount = 0;
    for (int r = 0; r < PH; r++) begin
      for (int c = 0; c < PW; c++) begin
        pix_beat(r == 0 && c == 0);
        if (r == 4 && c == 0) begin
          check_val("t1_first_vld", 32'(valid_out), 32'h1);
          check_val("t1_dout1", 32'(dout1), 32'h000000);
          check_val("t1_dout2", 32'(dout2), 32'h000100);
          check_val("t1_dout3", 32'(dout3), 32'h000200);
          check_val("t1_dout4", 32'(dout4), 32'h000300);
          check_val("t1_dout5", 32'(dout5), 32'h000400);
        end
`ifdef LINEBUF_ZERO_PAD_EN
        if (r == 1 && c == 3) begin
          check_val("t5_valid", 32'(valid_out), 32'h1);
          check_val("t5_dout1", 32'(dout1), 32'h000000);
          check_val("t5_dout2", 32'(dout2), 32'h000000);
          check_val("t5_dout3", 32'(dout3), 32'h000000);
          check_val("t5_dout4", 32'(dout4), 32'h000003);
          check_val("t5_dout5", 32'(dout5), 32'h000103);
        end
`endif
      end
    end
    check_val("t1_vld_count", 32'(vcount), 32'(FRAME_VLD));

    // Second frame without sof: row wrap alone must restart priming.
    run_frame(1'b0, 1'b0, "t6");

    // Random idle gaps between beats.
    run_frame(1'b1, 1'b1, "t2");

    // sof arriving mid-line at pixel (2,5).
    for (int i = 0; i < 2 * PW + 5; i++) pix_beat(i == 0);
    pix_beat(1'b1);
    check_val("t3_sof_col", 32'(col_out), 32'h0);
    check_val("t3_sof_row", 32'(row_out), 32'h0);
    first = 0;
    for (int i = 1; i <= 32; i++) begin
      pix_beat(1'b0);
      if (valid_out && first == 0) first = i;
    end
    check_val("t3_first_vld_beat", 32'(first), ZP ? 32'd1 : 32'd32);

    // Reset pulse mid-row 4, then restart from (0,0) without sof.
    for (int i = 0; i < 4 * PW + 3; i++) pix_beat(i == 0);
    rst_n = 1'b0;
    #1;
    check_zero("t4_rst0");
    @(posedge clk);
    #1;
    check_zero("t4_rst1");
    @(posedge clk);
    #1;
    check_zero("t4_rst2");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mr = 0; mc = 0;
    last5 = '0; last_col = 0; last_row = 0;
    idle_cyc();
    run_frame(1'b0, 1'b0, "t4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/linebuf_5row.md
# linebuf_5row

- Produces the five vertically aligned row taps that feed the 5x5 Gaussian window stage.
- Accepts a single raster-order pixel stream (one pixel per `valid_in` beat) and keeps the four previous image lines in internal line memories.
- For each input pixel it presents that pixel and the four pixels directly above it in the same column, on five parallel outputs, with a matching `valid_out`.
- Sits between the video/pixel source and `matrix_5x5`-style window consumers.

## Interface
- `WIDTH`, 24: pixel width, {R[23:16], G[15:8], B[7:0]}; opaque to this block.
- `PIC_WIDTH`, 480: pixels per line; line-memory depth.
- `PIC_HEIGHT`, 272: lines per frame.
- `clk` in 1: clock.
- `rst_n` in 1: reset rst_n, asynchronous, active-low; clock clk.
- `valid_in` in 1: `din` carries a pixel this cycle.
- `sof` in 1: start of frame; qualified by `valid_in`; marks `din` as pixel (row 0, col 0).
- `din` in WIDTH: input pixel.
- `valid_out` out 1: outputs carry a valid column.
- `dout1` out WIDTH: pixel at (row-4, col), the oldest row.
- `dout2` out WIDTH: pixel at (row-3, col).
- `dout3` out WIDTH: pixel at (row-2, col).
- `dout4` out WIDTH: pixel at (row-1, col).
- `dout5` out WIDTH: pixel at (row, col), the current pixel.
- `col_out` out clog2(PIC_WIDTH): column of `dout5`.
- `row_out` out clog2(PIC_HEIGHT): row of `dout5`.

## Operation
- **Counters.** `col` runs 0..PIC_WIDTH-1 and advances only on `valid_in`.
  - At PIC_WIDTH-1 it wraps to 0 and `row` increments.
  - `row` wraps to 0 after PIC_HEIGHT-1.
  - Both counters hold while `valid_in` is low; stalls never reset position.
- **sof.** `valid_in && sof` forces the current pixel to position (0,0), overriding the counter state. The counters then continue from col 1.
- **Line memories.** Four memories L1..L4, each PIC_WIDTH x WIDTH, single read/write port per column address.
  - On each `valid_in` beat at column c, read L1[c]..L4[c] first.
  - Then write L1[c]<=din, L2[c]<=old L1[c], L3[c]<=old L2[c], L4[c]<=old L3[c].
  - Output mapping: dout5=din, dout4=old L1[c], dout3=old L2[c], dout2=old L3[c], dout1=old L4[c].
- **Priming.** `fill` counts completed lines in the current frame, saturating at 4. It is cleared by sof, by the row wrap, and by reset.
  - `valid_out` asserts only for pixels with row >= 4, unless the `_EN` option is enabled (see Configuration).
- **Data path.** No arithmetic; pixel data is passed bit-exact.
- **Reset.** Counters, `fill`, `valid_out`, all `dout*`, `col_out` and `row_out` go to 0. Memory contents are not cleared; priming masks stale data.
- **Reset mid-frame.** The next accepted pixel is treated as (0,0) and priming restarts.

## Timing
- Latency is 1 cycle: `dout*`, `col_out`, `row_out` and `valid_out` are registered at the edge after the accepted `valid_in` beat.
- `valid_out` is high for exactly one cycle per accepted beat (when unmasked) and low on idle cycles.
- `dout*`, `col_out` and `row_out` hold their last values while `valid_out` is low.
- Throughput: one pixel per clock; back-to-back `valid_in` is supported indefinitely with no backpressure.
- **sof arriving mid-line.** It takes priority: the partial line is discarded, memory columns already written stay stale, and priming masks them.
- **sof and row wrap on the same beat.** Result is identical to sof alone.

## Configuration
- `LINEBUF_ZERO_PAD_EN`, defined:
  - `valid_out` asserts for every accepted pixel from row 0.
  - For row r < 4, tap outputs whose source row would be negative (dout1..dout(4-r)) are forced to 0. This gives zero top-border padding and one output per input pixel.
- `LINEBUF_ZERO_PAD_EN`, undefined: the first 4*PIC_WIDTH pixels of each frame produce no `valid_out`.

## Test plan
All scenarios use PIC_WIDTH=8, PIC_HEIGHT=6, and pixel value = {8'h00, row, col}.

1. **Full frame, continuous `valid_in`.**
   - First `valid_out` appears 1 cycle after pixel (4,0), with dout1..dout5 = 0x000000, 0x000100, 0x000200, 0x000300, 0x000400.
   - Exactly 16 valid beats per frame.
2. **Random `valid_in` gaps (~50% duty).**
   - Outputs are identical in sequence to scenario 1.
   - `col_out` and `row_out` track correctly, and outputs hold during gaps.
3. **sof asserted at pixel (2,5).**
   - That pixel is reported as (0,0).
   - No `valid_out` occurs until 32 further beats have been accepted.
4. **`rst_n` pulsed low for 3 cycles mid-row 4.**
   - All outputs read 0 during reset.
   - After release, the pixel stream restarts priming from (0,0).
5. **With `LINEBUF_ZERO_PAD_EN`, pixel (1,3).**
   - dout1..dout5 = 0, 0, 0, 0x000003, 0x000103, with `valid_out` high.
   - 48 valid beats per frame.
6. **Two consecutive frames with no sof.**
   - At the row wrap, frame 2 pixel (0,0) produces no `valid_out`; frame 1 data is masked.
